// File: rtl/switch_allocator.sv
// switch_allocator
//   Per-router switch allocator with wormhole output locking. Each output
//   port runs its own round-robin arbiter over the inputs whose (one-hot)
//   route request targets it. A head flit without a tail locks the output
//   to its input until the tail flit has crossed.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   i_output_req [i][j]: input i requests output j (rows must be one-hot)
//   i_tail       [i]: head flit of input i is a tail flit
//   i_en         [j]: output j has downstream credit this cycle
//   o_grant      [i]: input i's head flit crosses the crossbar this cycle
//   o_xbar_sel   [j][i]: output j is driven by input i (row one-hot or zero)
//   o_out_valid  [j]: output j carries a flit this cycle
module switch_allocator #(
    parameter int N_PORTS = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [0:N_PORTS-1][0:N_PORTS-1]   i_output_req,
    input  logic [0:N_PORTS-1]                i_tail,
    input  logic [0:N_PORTS-1]                i_en,
    output logic [0:N_PORTS-1]                o_grant,
    output logic [0:N_PORTS-1][0:N_PORTS-1]   o_xbar_sel,
    output logic [0:N_PORTS-1]                o_out_valid
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } lock_t;

    typedef logic [PW-1:0] idx_t;

    lock_t lock_q  [N_PORTS];
    lock_t lock_d  [N_PORTS];
    idx_t  owner_q [N_PORTS];
    idx_t  owner_d [N_PORTS];
    idx_t  ptr_q   [N_PORTS];
    idx_t  ptr_d   [N_PORTS];

    logic [0:N_PORTS-1]              row_ok;
    logic [0:N_PORTS-1][0:N_PORTS-1] sel;

    // Rows with more than one bit set are treated as "no request".
    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            row_ok[i] = $onehot(i_output_req[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned j = 0; j < N_PORTS; j++) begin
                lock_q[j]  <= IDLE;
                owner_q[j] <= '0;
                ptr_q[j]   <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < N_PORTS; j++) begin
                lock_q[j]  <= lock_d[j];
                owner_q[j] <= owner_d[j];
                ptr_q[j]   <= ptr_d[j];
            end
        end
    end

    always_comb begin : alloc
        logic        found;
        idx_t        win;
        int unsigned cand;
        sel = '0;
        for (int unsigned j = 0; j < N_PORTS; j++) begin
            lock_d[j]  = lock_q[j];
            owner_d[j] = owner_q[j];
            ptr_d[j]   = ptr_q[j];
            found      = 1'b0;
            win        = '0;
            cand       = 0;
            unique case (lock_q[j])
                IDLE: begin
                    // First eligible input at or above ptr, wrapping around.
                    for (int unsigned k = 0; k < N_PORTS; k++) begin
                        cand = (32'(ptr_q[j]) + k) % N_PORTS;
                        if (!found && row_ok[cand] && i_output_req[cand][j]) begin
                            found = 1'b1;
                            win   = idx_t'(cand);
                        end
                    end
                    if (found && i_en[j]) begin
                        sel[j][win] = 1'b1;
                        if (i_tail[win]) begin
                            ptr_d[j] = idx_t'((32'(win) + 1) % N_PORTS);
                        end else begin
                            lock_d[j]  = LOCKED;
                            owner_d[j] = win;
                        end
                    end
                end
                LOCKED: begin
                    // Only the owner may move; others wait even if it stalls.
                    if (row_ok[owner_q[j]] && i_output_req[owner_q[j]][j] && i_en[j]) begin
                        sel[j][owner_q[j]] = 1'b1;
                        if (i_tail[owner_q[j]]) begin
                            lock_d[j] = IDLE;
                            ptr_d[j]  = idx_t'((32'(owner_q[j]) + 1) % N_PORTS);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_xbar_sel = reset ? '0 : sel;
        o_grant    = '0;
        for (int unsigned j = 0; j < N_PORTS; j++) begin
            o_out_valid[j] = |o_xbar_sel[j];
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                o_grant[i] = o_grant[i] | o_xbar_sel[j][i];
            end
        end
    end

endmodule
